// File: rtl/wisc_pkg.sv
package wisc_pkg;

  localparam int unsigned REG_W = 16;
  localparam int unsigned NREG  = 16;

  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_NOP1 = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_NOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_NOP8 = 4'h8,
    OP_NOP9 = 4'h9,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB,
    OP_B    = 4'hC,
    OP_NOPD = 4'hD,
    OP_NOPE = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    BC_NE  = 3'b000,
    BC_EQ  = 3'b001,
    BC_GT  = 3'b010,
    BC_LT  = 3'b011,
    BC_GTE = 3'b100,
    BC_LTE = 3'b101,
    BC_OVF = 3'b110,
    BC_UNC = 3'b111
  } bcond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] ir;
    logic [15:0] pc;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    opcode_e     op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  imm8;
  } idex_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  rd;
    logic [15:0] res;
  } wb_t;

  function automatic logic writes_rd(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_LHB, OP_LLB};
  endfunction

  function automatic logic cond_met(bcond_e c, flags_t f);
    case (c)
      BC_NE:   return !f.z;
      BC_EQ:   return f.z;
      BC_GT:   return !f.z && !f.n;
      BC_LT:   return f.n;
      BC_GTE:  return f.z || !f.n;
      BC_LTE:  return f.n || f.z;
      BC_OVF:  return f.v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] fwd(logic [3:0] r, logic [15:0] v, wb_t m, wb_t w);
    if (m.wr && m.rd == r) return m.res;
    if (w.wr && w.rd == r) return w.res;
    return v;
  endfunction

endpackage

// File: rtl/wisc_pipeline_core_reg_file.sv
// 16x16 register file, write-before-read, R0 hard zero.
module reg_file
  import wisc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  ra1,
  input  logic [3:0]                  ra2,
  input  logic [3:0]                  ra3,
  output logic [REG_W-1:0]            rd1,
  output logic [REG_W-1:0]            rd2,
  output logic [REG_W-1:0]            rd3,
  input  logic                        we,
  input  logic [3:0]                  wa,
  input  logic [REG_W-1:0]            wd,
  output logic [NREG-1:0][REG_W-1:0]  regs
);

  logic [NREG-1:0][REG_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    rd3 = mem[ra3];
    if (we && wa != '0) begin
      if (ra1 == wa) rd1 = wd;
      if (ra2 == wa) rd2 = wd;
      if (ra3 == wa) rd3 = wd;
    end
  end

  assign regs = mem;

endmodule

// File: rtl/wisc_pipeline_core.sv
// 5-stage WISC core: branch resolved in ID, one delay slot, full EX forwarding.
module wisc_pipeline_core
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  output logic [15:0] PC,
  output logic [15:0] IFID,
  output logic [15:0] R0,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] R3,
  output logic [15:0] R4,
  output logic [15:0] R5,
  output logic [15:0] R6,
  output logic [15:0] R7,
  output logic [15:0] R8,
  output logic [15:0] R9,
  output logic [15:0] R10,
  output logic [15:0] R11,
  output logic [15:0] R12,
  output logic [15:0] R13,
  output logic [15:0] R14,
  output logic [15:0] R15,
  output logic        N_ff,
  output logic        Z_ff,
  output logic        V_ff
);

  ifid_t   ifid;
  idex_t   idex;
  wb_t     exmem;
  wb_t     memwb;
  flags_t  flags_q;
  flags_t  flags_nxt;
  logic    halted;

  opcode_e     id_op;
  bcond_e      id_cond;
  logic [8:0]  id_imm9;
  logic [15:0] br_target;
  logic        taken;
  logic        freeze;
  logic [15:0] rf_rd1, rf_rd2, rf_rd3;
  logic [NREG-1:0][REG_W-1:0] regs;

  logic [15:0] ex_a, ex_b, ex_c, ex_res;
  logic        ex_ovf;
  logic        ex_wr;

  // ---------------- IF / ID ----------------
  assign id_op     = opcode_e'(ifid.ir[15:12]);
  assign id_cond   = bcond_e'(ifid.ir[11:9]);
  assign id_imm9   = ifid.ir[8:0];
  assign br_target = ifid.pc + 16'd1 + {{7{id_imm9[8]}}, id_imm9};
  // flags_nxt is what the EX instruction will leave behind, so the branch sees it a cycle early
  assign taken     = ifid.vld && id_op == OP_B && cond_met(id_cond, flags_nxt);
  assign freeze    = halted || (ifid.vld && id_op == OP_HLT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC     <= RESET_PC;
      ifid   <= '{vld: 1'b0, ir: NOP, pc: RESET_PC};
      halted <= 1'b0;
    end else if (freeze) begin
      // injected bubbles carry vld=0 so they never touch flags
      ifid   <= '{vld: 1'b0, ir: NOP, pc: PC};
      halted <= 1'b1;
    end else begin
      PC   <= taken ? br_target : PC + 16'd1;
      ifid <= '{vld: 1'b1, ir: instr, pc: PC};
    end
  end

  reg_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ifid.ir[7:4]),
    .ra2   (ifid.ir[3:0]),
    .ra3   (ifid.ir[11:8]),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .rd3   (rf_rd3),
    .we    (memwb.wr),
    .wa    (memwb.rd),
    .wd    (memwb.res),
    .regs  (regs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex <= '0;
    end else begin
      idex <= '{vld:  ifid.vld,
                op:   id_op,
                rd:   ifid.ir[11:8],
                rs:   ifid.ir[7:4],
                rt:   ifid.ir[3:0],
                a:    rf_rd1,
                b:    rf_rd2,
                c:    rf_rd3,
                imm8: ifid.ir[7:0]};
    end
  end

  // ---------------- EX ----------------
  always_comb begin
    ex_a      = fwd(idex.rs, idex.a, exmem, memwb);
    ex_b      = fwd(idex.rt, idex.b, exmem, memwb);
    ex_c      = fwd(idex.rd, idex.c, exmem, memwb);
    ex_res    = '0;
    ex_ovf    = 1'b0;
    flags_nxt = flags_q;
    case (idex.op)
      OP_ADD: begin
        ex_res = ex_a + ex_b;
        ex_ovf = (ex_a[15] == ex_b[15]) && (ex_res[15] != ex_a[15]);
      end
      OP_SUB: begin
        ex_res = ex_a - ex_b;
        ex_ovf = (ex_a[15] != ex_b[15]) && (ex_res[15] != ex_a[15]);
      end
      OP_AND:  ex_res = ex_a & ex_b;
      OP_NOR:  ex_res = ~(ex_a | ex_b);
      OP_SLL:  ex_res = ex_a << idex.rt;
      OP_SRL:  ex_res = ex_a >> idex.rt;
      OP_SRA:  ex_res = $signed(ex_a) >>> idex.rt;
      OP_LHB:  ex_res = {idex.imm8, 8'h00} | (ex_c & 16'h00FF);
      OP_LLB:  ex_res = {{8{idex.imm8[7]}}, idex.imm8};
      default: ex_res = '0;
    endcase
    if (idex.vld) begin
      if (idex.op inside {OP_ADD, OP_SUB}) begin
        flags_nxt = '{n: ex_res[15], z: (ex_res == '0), v: ex_ovf};
      end else if (idex.op inside {OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA}) begin
        flags_nxt.z = (ex_res == '0);
      end
    end
  end

  assign ex_wr = idex.vld && writes_rd(idex.op) && idex.rd != '0;

  // ---------------- EX/MEM, MEM/WB, flags ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exmem   <= '0;
      memwb   <= '0;
      flags_q <= '0;
    end else begin
      exmem   <= '{wr: ex_wr, rd: idex.rd, res: ex_res};
      memwb   <= exmem;
      flags_q <= flags_nxt;
    end
  end

  assign IFID = ifid.ir;
  assign N_ff = flags_q.n;
  assign Z_ff = flags_q.z;
  assign V_ff = flags_q.v;

  assign R0  = regs[0];
  assign R1  = regs[1];
  assign R2  = regs[2];
  assign R3  = regs[3];
  assign R4  = regs[4];
  assign R5  = regs[5];
  assign R6  = regs[6];
  assign R7  = regs[7];
  assign R8  = regs[8];
  assign R9  = regs[9];
  assign R10 = regs[10];
  assign R11 = regs[11];
  assign R12 = regs[12];
  assign R13 = regs[13];
  assign R14 = regs[14];
  assign R15 = regs[15];

endmodule

// File: tb/tb_wisc_pipeline_core.sv
module tb_wisc_pipeline_core;

  localparam int unsigned S_PC   = 16;
  localparam int unsigned S_IFID = 17;
  localparam int unsigned S_N    = 18;
  localparam int unsigned S_Z    = 19;
  localparam int unsigned S_V    = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        garbage;
  logic [15:0] instr;
  logic [15:0] PC, IFID;
  logic [15:0] R [16];
  logic        N_ff, Z_ff, V_ff;
  logic [15:0] rom [64];

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign instr = garbage ? 16'hF00D : rom[PC[5:0]];

  wisc_pipeline_core #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .instr (instr),
    .PC    (PC),
    .IFID  (IFID),
    .R0    (R[0]),
    .R1    (R[1]),
    .R2    (R[2]),
    .R3    (R[3]),
    .R4    (R[4]),
    .R5    (R[5]),
    .R6    (R[6]),
    .R7    (R[7]),
    .R8    (R[8]),
    .R9    (R[9]),
    .R10   (R[10]),
    .R11   (R[11]),
    .R12   (R[12]),
    .R13   (R[13]),
    .R14   (R[14]),
    .R15   (R[15]),
    .N_ff  (N_ff),
    .Z_ff  (Z_ff),
    .V_ff  (V_ff)
  );

  function automatic logic [15:0] r3(logic [3:0] op, logic [3:0] rd, logic [3:0] rs, logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [15:0] i8(logic [3:0] op, logic [3:0] rd, logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [15:0] br(logic [2:0] cond, logic [8:0] imm9);
    return {4'hC, cond, imm9};
  endfunction

  localparam logic [15:0] HLT = 16'hF000;

  function automatic logic [15:0] observe(int unsigned sel);
    if (sel < 16) return R[sel[3:0]];
    case (sel)
      S_PC:    return PC;
      S_IFID:  return IFID;
      S_N:     return {15'b0, N_ff};
      S_Z:     return {15'b0, Z_ff};
      default: return {15'b0, V_ff};
    endcase
  endfunction

  task automatic exp_push(string tag, int unsigned sel, logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic exp_reg(string tag, int unsigned r, logic [15:0] v);
    exp_push($sformatf("%s_R%0d", tag, r), r, v);
  endtask

  task automatic exp_flags(string tag, logic n, logic z, logic v);
    exp_push({tag, "_N"}, S_N, {15'b0, n});
    exp_push({tag, "_Z"}, S_Z, {15'b0, z});
    exp_push({tag, "_V"}, S_V, {15'b0, v});
  endtask

  task automatic exp_reset(string tag);
    for (int unsigned i = 0; i < 16; i++) exp_reg(tag, i, 16'h0000);
    exp_push({tag, "_PC"}, S_PC, 16'h0000);
    exp_push({tag, "_IFID"}, S_IFID, 16'h0000);
    exp_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int unsigned i = 0; i < 64; i++) rom[i] = 16'h1000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] trb [8];

    rst_n   = 1'b0;
    garbage = 1'b1;
    clear_rom();

    // reset with garbage on the instruction bus
    step(2);
    exp_reset("rst");
    drain();

    // program A: byte loads, R0 discard, ALU forwarding chain
    rom[0]  = i8(4'hA, 4'd1, 8'h00);
    rom[1]  = i8(4'hB, 4'd1, 8'h05);
    rom[2]  = i8(4'hA, 4'd1, 8'hAA);
    rom[3]  = i8(4'hB, 4'd0, 8'h7F);
    rom[4]  = r3(4'h0, 4'd6, 4'd0, 4'd1);
    rom[5]  = i8(4'hB, 4'd2, 8'h2B);
    rom[6]  = r3(4'h0, 4'd3, 4'd2, 4'd2);
    rom[7]  = r3(4'h0, 4'd4, 4'd3, 4'd0);
    rom[8]  = r3(4'h2, 4'd5, 4'd3, 4'd4);
    rom[9]  = HLT;
    garbage = 1'b0;
    rst_n   = 1'b1;
    step(40);
    exp_reg("a", 0, 16'h0000);
    exp_reg("a", 1, 16'hAA05);
    exp_reg("a", 6, 16'hAA05);
    exp_reg("a", 2, 16'h002B);
    exp_reg("a", 3, 16'h0056);
    exp_reg("a", 4, 16'h0056);
    exp_reg("a", 5, 16'h0000);
    exp_flags("a", 1'b0, 1'b1, 1'b0);
    exp_push("a_PC", S_PC, 16'h000A);
    exp_push("a_IFID", S_IFID, 16'h0000);
    drain();

    // program B: delayed branches forward and backward
    rst_n = 1'b0;
    step(1);
    clear_rom();
    rom[0] = i8(4'hB, 4'd7, 8'h01);
    rom[1] = br(3'b111, 9'd6);
    rom[2] = i8(4'hB, 4'd15, 8'h0F);
    rom[3] = i8(4'hB, 4'd15, 8'h33);
    rom[4] = i8(4'hB, 4'd15, 8'h44);
    rom[5] = r3(4'h0, 4'd8, 4'd7, 4'd15);
    rom[6] = HLT;
    rom[8] = br(3'b111, 9'h1FC);
    rom[9] = i8(4'hB, 4'd6, 8'h66);
    rst_n  = 1'b1;
    trb = '{16'h0001, 16'h0002, 16'h0008, 16'h0009, 16'h0005, 16'h0006, 16'h0007, 16'h0007};
    for (int i = 0; i < 8; i++) begin
      step(1);
      exp_push($sformatf("b_pc%0d", i), S_PC, trb[i]);
      drain();
    end
    step(20);
    exp_reg("b", 15, 16'h000F);
    exp_reg("b", 8, 16'h0010);
    exp_reg("b", 6, 16'h0066);
    exp_reg("b", 7, 16'h0001);
    exp_flags("b", 1'b0, 1'b0, 1'b0);
    drain();

    // program C: flag forwarding into not-taken branch, overflow, V branch
    rst_n = 1'b0;
    step(1);
    clear_rom();
    rom[0]  = i8(4'hB, 4'd1, 8'h05);
    rom[1]  = i8(4'hB, 4'd2, 8'h03);
    rom[2]  = r3(4'h2, 4'd4, 4'd1, 4'd1);
    rom[3]  = r3(4'h2, 4'd3, 4'd1, 4'd2);
    rom[4]  = br(3'b001, 9'd4);
    rom[5]  = i8(4'hB, 4'd9, 8'h11);
    rom[6]  = i8(4'hB, 4'd10, 8'h22);
    rom[7]  = i8(4'hB, 4'd11, 8'hFF);
    rom[8]  = i8(4'hA, 4'd11, 8'h7F);
    rom[9]  = i8(4'hB, 4'd12, 8'h01);
    rom[10] = r3(4'h0, 4'd13, 4'd11, 4'd12);
    rom[11] = br(3'b110, 9'd2);
    rom[12] = i8(4'hB, 4'd14, 8'h44);
    rom[13] = i8(4'hB, 4'd14, 8'h55);
    rom[14] = HLT;
    rst_n   = 1'b1;
    step(40);
    exp_reg("c", 3, 16'h0002);
    exp_reg("c", 4, 16'h0000);
    exp_reg("c", 9, 16'h0011);
    exp_reg("c", 10, 16'h0022);
    exp_reg("c", 11, 16'h7FFF);
    exp_reg("c", 12, 16'h0001);
    exp_reg("c", 13, 16'h8000);
    exp_reg("c", 14, 16'h0044);
    exp_flags("c", 1'b1, 1'b0, 1'b1);
    exp_push("c_PC", S_PC, 16'h000F);
    drain();

    // program D: shifts/logic set Z only; HLT in a taken branch's delay slot
    rst_n = 1'b0;
    step(1);
    clear_rom();
    rom[0]  = i8(4'hB, 4'd1, 8'h81);
    rom[1]  = r3(4'h7, 4'd2, 4'd1, 4'd4);
    rom[2]  = r3(4'h6, 4'd3, 4'd1, 4'd4);
    rom[3]  = r3(4'h5, 4'd4, 4'd1, 4'd4);
    rom[4]  = r3(4'h3, 4'd5, 4'd2, 4'd3);
    rom[5]  = r3(4'h4, 4'd6, 4'd5, 4'd4);
    rom[6]  = r3(4'h0, 4'd9, 4'd4, 4'd4);
    rom[7]  = r3(4'h6, 4'd8, 4'd6, 4'd4);
    rom[8]  = br(3'b101, 9'd5);
    rom[9]  = HLT;
    rom[14] = i8(4'hB, 4'd10, 8'h99);
    rst_n   = 1'b1;
    step(40);
    exp_reg("d", 1, 16'hFF81);
    exp_reg("d", 2, 16'hFFF8);
    exp_reg("d", 3, 16'h0FF8);
    exp_reg("d", 4, 16'hF810);
    exp_reg("d", 5, 16'h0FF8);
    exp_reg("d", 6, 16'h0007);
    exp_reg("d", 9, 16'hF020);
    exp_reg("d", 8, 16'h0000);
    exp_reg("d", 10, 16'h0000);
    exp_flags("d", 1'b1, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 20; i++) begin
      step(1);
      exp_push($sformatf("halt_pc%0d", i), S_PC, 16'h000E);
      exp_push($sformatf("halt_ifid%0d", i), S_IFID, 16'h0000);
      drain();
    end
    exp_reg("halt", 9, 16'hF020);
    exp_reg("halt", 6, 16'h0007);
    exp_reg("halt", 10, 16'h0000);
    exp_flags("halt", 1'b1, 1'b1, 1'b0);
    drain();

    // reset pulse while halted
    rst_n = 1'b0;
    step(1);
    exp_reset("rst_halt");
    drain();

    // reset mid-run after R1 has been written
    rst_n = 1'b1;
    step(7);
    exp_reg("run", 1, 16'hFF81);
    drain();
    rst_n = 1'b0;
    step(1);
    exp_reset("rst_run");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
